guarded_cmd_fsm: RTL and testbench

Parametrised, hardened successor to the team's control-driven state machine. Accepts opcode commands over a valid/ready handshake and allows only whitelisted transitions. Any illegal command or corrupted state encoding goes to a locked FAULT state, which only an explicit CLEAR after a lockout period can leave. Every state has a fully defined output pattern; no X is ever driven. Sits between the host control register block and downstream datapath enables.

---
 rtl/guarded_cmd_pkg.sv | 52 +++++
 rtl/guarded_cmd_fsm_sat_down_timer.sv | 28 ++
 rtl/guarded_cmd_fsm.sv | 164 ++++++++++++++++
 tb/tb_guarded_cmd_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/guarded_cmd_pkg.sv
// Shared opcode/state encodings and per-state output byte patterns for guarded_cmd_fsm.
package guarded_cmd_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned LANE_W   = 8;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP    = 3'd0,
    OP_ARM    = 3'd1,
    OP_START  = 3'd2,
    OP_PAUSE  = 3'd3,
    OP_RESUME = 3'd4,
    OP_STOP   = 3'd5,
    OP_CLEAR  = 3'd6,
    OP_RSVD   = 3'd7
  } opcode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam logic [LANE_W-1:0] PAT_IDLE    = 8'h55;
  localparam logic [LANE_W-1:0] PAT_ARMED   = 8'hAA;
  localparam logic [LANE_W-1:0] PAT_ACTIVE  = 8'hFF;
  localparam logic [LANE_W-1:0] PAT_PAUSED  = 8'h0F;
  localparam logic [LANE_W-1:0] PAT_DRAIN   = 8'hF0;
  localparam logic [LANE_W-1:0] PAT_FAULT   = 8'h00;
  localparam logic [LANE_W-1:0] PAT_INVALID = 8'h00;

  // One byte lane of the state pattern; invalid encodings decode to all-zero.
  function automatic logic [LANE_W-1:0] state_pattern(input logic [STATE_W-1:0] s);
    logic [LANE_W-1:0] pat;
    pat = PAT_INVALID;
    case (s)
      ST_IDLE:   pat = PAT_IDLE;
      ST_ARMED:  pat = PAT_ARMED;
      ST_ACTIVE: pat = PAT_ACTIVE;
      ST_PAUSED: pat = PAT_PAUSED;
      ST_DRAIN:  pat = PAT_DRAIN;
      ST_FAULT:  pat = PAT_FAULT;
      default:   pat = PAT_INVALID;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/guarded_cmd_fsm_sat_down_timer.sv
// Loadable down-counter that stops at zero; done_c is high whenever the count is zero.
module sat_down_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] count_q;

  // Load wins over decrement so a fresh entry always restarts the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/guarded_cmd_fsm.sv
// Whitelisted command state machine with timed DRAIN, locked FAULT and a saturating fault counter.
module guarded_cmd_fsm
  import guarded_cmd_pkg::*;
#(
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FAULT_LOCK  = 16,
  parameter int unsigned CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  output logic               cmd_ready,
  output logic [OUT_W-1:0]   state_output,
  output logic [2:0]         state_id,
  output logic               fault,
  output logic [CNT_W-1:0]   fault_count,
  output logic               busy
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam int unsigned LOCK_W = $clog2(FAULT_LOCK + 1);

  // Plain vectors rather than the enum type so that corrupted values 6/7 stay representable.
  localparam logic [STATE_W-1:0] S_IDLE   = ST_IDLE;
  localparam logic [STATE_W-1:0] S_ARMED  = ST_ARMED;
  localparam logic [STATE_W-1:0] S_ACTIVE = ST_ACTIVE;
  localparam logic [STATE_W-1:0] S_PAUSED = ST_PAUSED;
  localparam logic [STATE_W-1:0] S_DRAIN  = ST_DRAIN;
  localparam logic [STATE_W-1:0] S_FAULT  = ST_FAULT;

  if ((OUT_W < 8) || ((OUT_W % 8) != 0)) begin : g_bad_out_w
    $error("guarded_cmd_fsm: OUT_W must be a non-zero multiple of 8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("guarded_cmd_fsm: HOLD_CYCLES must be at least 1");
  end
  if (FAULT_LOCK < 1) begin : g_bad_lock
    $error("guarded_cmd_fsm: FAULT_LOCK must be at least 1");
  end

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state_c;
  logic [CNT_W-1:0]   fault_count_q;
  logic               ready_c;
  logic               accept_c;
  logic               enter_fault_c;
  logic               enter_drain_c;
  logic               drain_done_c;
  logic               lock_done_c;

  // Hold period: loaded with HOLD_CYCLES-1 so the zero-count cycle is the last DRAIN cycle.
  sat_down_timer #(.W(HOLD_W)) u_drain_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (enter_drain_c),
    .load_value (HOLD_W'(HOLD_CYCLES - 1)),
    .en         (state_q == S_DRAIN),
    .done_c     (drain_done_c)
  );

  // Lockout: loaded with FAULT_LOCK so ready rises on the first cycle after the lock period.
  sat_down_timer #(.W(LOCK_W)) u_lock_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (enter_fault_c),
    .load_value (LOCK_W'(FAULT_LOCK)),
    .en         (state_q == S_FAULT),
    .done_c     (lock_done_c)
  );

  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      S_IDLE, S_ARMED, S_ACTIVE, S_PAUSED: ready_c = 1'b1;
      S_FAULT:                             ready_c = lock_done_c;
      default:                             ready_c = 1'b0;
    endcase
  end

  assign accept_c = cmd_valid && ready_c;

  always_comb begin
    next_state_c = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          case (cmd)
            OP_ARM:          next_state_c = S_ARMED;
            OP_NOP, OP_STOP: next_state_c = S_IDLE;
            default:         next_state_c = S_FAULT;
          endcase
        end
      end
      S_ARMED: begin
        if (accept_c) begin
          case (cmd)
            OP_START: next_state_c = S_ACTIVE;
            OP_STOP:  next_state_c = S_IDLE;
            OP_NOP:   next_state_c = S_ARMED;
            default:  next_state_c = S_FAULT;
          endcase
        end
      end
      S_ACTIVE: begin
        if (accept_c) begin
          case (cmd)
            OP_PAUSE: next_state_c = S_PAUSED;
            OP_STOP:  next_state_c = S_DRAIN;
            OP_NOP:   next_state_c = S_ACTIVE;
            default:  next_state_c = S_FAULT;
          endcase
        end
      end
      S_PAUSED: begin
        if (accept_c) begin
          case (cmd)
            OP_RESUME: next_state_c = S_ACTIVE;
            OP_STOP:   next_state_c = S_DRAIN;
            OP_NOP:    next_state_c = S_PAUSED;
            default:   next_state_c = S_FAULT;
          endcase
        end
      end
      S_DRAIN: begin
        if (drain_done_c) next_state_c = S_IDLE;
      end
      S_FAULT: begin
        // Non-CLEAR opcodes are consumed without restarting the lockout.
        if (accept_c && (cmd == OP_CLEAR)) next_state_c = S_IDLE;
      end
      default: next_state_c = S_FAULT;
    endcase
  end

  assign enter_fault_c = (next_state_c == S_FAULT) && (state_q != S_FAULT);
  assign enter_drain_c = (next_state_c == S_DRAIN) && (state_q != S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= next_state_c;
    end
  end

  // Fault entry counter; only reset clears it, CLEAR leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_count_q <= '0;
    end else if (enter_fault_c && (fault_count_q != '1)) begin
      fault_count_q <= fault_count_q + CNT_W'(1);
    end
  end

  assign cmd_ready    = ready_c;
  assign state_id     = state_q;
  assign fault        = (state_q == S_FAULT);
  assign busy         = (state_q == S_ACTIVE) || (state_q == S_PAUSED) || (state_q == S_DRAIN);
  assign fault_count  = fault_count_q;
  assign state_output = {(OUT_W / LANE_W){state_pattern(state_q)}};

endmodule

// File: tb/tb_guarded_cmd_fsm.sv
// Directed bench for guarded_cmd_fsm: default config, CNT_W=2 saturation, and OUT_W=32/short timers.
module tb_guarded_cmd_fsm;
  import guarded_cmd_pkg::*;

  typedef struct {
    logic       valid;
    logic [2:0] cmd;
    logic [2:0] id;
    logic [7:0] out;
    logic       rdy;
    logic       flt;
    logic       bsy;
    logic [3:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [2:0]  c0 = 3'd0, c1 = 3'd0, c2 = 3'd0;
  logic        rdy0, rdy1, rdy2, flt0, flt1, flt2, bsy0, bsy1, bsy2;
  logic [7:0]  out0, out1;
  logic [31:0] out2;
  logic [2:0]  id0, id1, id2;
  logic [3:0]  cnt0, cnt2;
  logic [1:0]  cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  always #5 clk = ~clk;

  guarded_cmd_fsm u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(v0), .cmd(c0), .cmd_ready(rdy0),
    .state_output(out0), .state_id(id0), .fault(flt0), .fault_count(cnt0), .busy(bsy0)
  );

  guarded_cmd_fsm #(.CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd(c1), .cmd_ready(rdy1),
    .state_output(out1), .state_id(id1), .fault(flt1), .fault_count(cnt1), .busy(bsy1)
  );

  guarded_cmd_fsm #(.OUT_W(32), .HOLD_CYCLES(1), .FAULT_LOCK(1)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(v2), .cmd(c2), .cmd_ready(rdy2),
    .state_output(out2), .state_id(id2), .fault(flt2), .fault_count(cnt2), .busy(bsy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic valid, input logic [2:0] cmd, input logic [2:0] id,
                              input logic [7:0] out, input logic rdy, input logic flt,
                              input logic bsy, input logic [3:0] cnt);
    vec_t v;
    v.valid = valid; v.cmd = cmd; v.id = id; v.out = out;
    v.rdy = rdy; v.flt = flt; v.bsy = bsy; v.cnt = cnt;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag, input int idx);
    v0 = v.valid;
    c0 = v.cmd;
    tick();
    check($sformatf("%s%0d_id", tag, idx),    32'(id0),  32'(v.id));
    check($sformatf("%s%0d_out", tag, idx),   32'(out0), 32'(v.out));
    check($sformatf("%s%0d_ready", tag, idx), 32'(rdy0), 32'(v.rdy));
    check($sformatf("%s%0d_fault", tag, idx), 32'(flt0), 32'(v.flt));
    check($sformatf("%s%0d_busy", tag, idx),  32'(bsy0), 32'(v.bsy));
    check($sformatf("%s%0d_cnt", tag, idx),   32'(cnt0), 32'(v.cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Normal flow, DRAIN hold, idle no-ops, then an illegal START.
    tbl_a.push_back(mk(1'b1, OP_ARM,    3'd1, 8'hAA, 1'b1, 1'b0, 1'b0, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_START,  3'd2, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_PAUSE,  3'd3, 8'h0F, 1'b1, 1'b0, 1'b1, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_RESUME, 3'd2, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_STOP,   3'd4, 8'hF0, 1'b0, 1'b0, 1'b1, 4'd0));
    tbl_a.push_back(mk(1'b0, OP_NOP,    3'd4, 8'hF0, 1'b0, 1'b0, 1'b1, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_START,  3'd4, 8'hF0, 1'b0, 1'b0, 1'b1, 4'd0));
    tbl_a.push_back(mk(1'b0, OP_NOP,    3'd4, 8'hF0, 1'b0, 1'b0, 1'b1, 4'd0));
    tbl_a.push_back(mk(1'b0, OP_NOP,    3'd0, 8'h55, 1'b1, 1'b0, 1'b0, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_NOP,    3'd0, 8'h55, 1'b1, 1'b0, 1'b0, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_STOP,   3'd0, 8'h55, 1'b1, 1'b0, 1'b0, 4'd0));
    tbl_a.push_back(mk(1'b1, OP_START,  3'd5, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1));
    // After lockout: STOP ignored, CLEAR returns to IDLE keeping the count.
    tbl_b.push_back(mk(1'b1, OP_STOP,   3'd5, 8'h00, 1'b1, 1'b1, 1'b0, 4'd1));
    tbl_b.push_back(mk(1'b1, OP_STOP,   3'd5, 8'h00, 1'b1, 1'b1, 1'b0, 4'd1));
    tbl_b.push_back(mk(1'b1, OP_CLEAR,  3'd0, 8'h55, 1'b1, 1'b0, 1'b0, 4'd1));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("rst_id",    32'(id0),  32'd0);
    check("rst_out",   32'(out0), 32'h55);
    check("rst_ready", 32'(rdy0), 32'd1);
    check("rst_fault", 32'(flt0), 32'd0);
    check("rst_busy",  32'(bsy0), 32'd0);
    check("rst_cnt",   32'(cnt0), 32'd0);
    check("rst_out32", out2,      32'h55555555);

    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], "a", i);

    // FAULT cycle 1 checked above; cycles 2..16 must keep ready low.
    v0 = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      tick();
      check($sformatf("lock_c%0d_ready", i), 32'(rdy0), 32'd0);
    end
    tick();
    check("lock_c17_ready", 32'(rdy0), 32'd1);
    check("lock_c17_id",    32'(id0),  32'd5);

    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], "b", i);

    // Async reset during DRAIN cycle 2.
    v0 = 1'b1; c0 = OP_ARM;   tick();
    c0 = OP_START; tick();
    c0 = OP_STOP;  tick();
    v0 = 1'b0;     tick();
    check("mid_drain_pre_id", 32'(id0), 32'd4);
    #3 rst = 1'b1;
    #1;
    check("mid_drain_rst_id",    32'(id0),  32'd0);
    check("mid_drain_rst_ready", 32'(rdy0), 32'd1);
    check("mid_drain_rst_cnt",   32'(cnt0), 32'd0);
    check("mid_drain_rst_out",   32'(out0), 32'h55);
    #2 rst = 1'b0;

    // Async reset during lock cycle 5.
    v0 = 1'b1; c0 = OP_START; tick();
    v0 = 1'b0;
    check("mid_lock_c1_cnt", 32'(cnt0), 32'd1);
    repeat (4) tick();
    check("mid_lock_c5_id",    32'(id0),  32'd5);
    check("mid_lock_c5_ready", 32'(rdy0), 32'd0);
    #3 rst = 1'b1;
    #1;
    check("mid_lock_rst_id",    32'(id0),  32'd0);
    check("mid_lock_rst_ready", 32'(rdy0), 32'd1);
    check("mid_lock_rst_fault", 32'(flt0), 32'd0);
    check("mid_lock_rst_cnt",   32'(cnt0), 32'd0);
    #2 rst = 1'b0;

    // Saturation with CNT_W=2: five fault entries, count sticks at 3.
    for (int n = 1; n <= 5; n++) begin
      int k;
      v1 = 1'b1; c1 = OP_START; tick();
      v1 = 1'b0;
      check($sformatf("sat%0d_id", n),  32'(id1),  32'd5);
      check($sformatf("sat%0d_cnt", n), 32'(cnt1), (n > 3) ? 32'd3 : 32'(n));
      k = 0;
      while (!rdy1 && (k < 40)) begin
        tick();
        k++;
      end
      check($sformatf("sat%0d_lock_wait", n), 32'(rdy1), 32'd1);
      v1 = 1'b1; c1 = OP_CLEAR; tick();
      v1 = 1'b0;
      check($sformatf("sat%0d_clear_id", n), 32'(id1), 32'd0);
    end

    // Wide output, 1-cycle DRAIN, 1-cycle lock, no-op holds.
    v2 = 1'b1; c2 = OP_ARM; tick();
    check("w_armed_id",  32'(id2), 32'd1);
    check("w_armed_out", out2,     32'hAAAAAAAA);
    c2 = OP_NOP; tick();
    check("w_nop_id", 32'(id2), 32'd1);
    v2 = 1'b0; c2 = OP_RSVD; tick();
    check("w_novalid_id",  32'(id2),  32'd1);
    check("w_novalid_cnt", 32'(cnt2), 32'd0);
    v2 = 1'b1; c2 = OP_START; tick();
    check("w_active_out", out2, 32'hFFFFFFFF);
    c2 = OP_STOP; tick();
    v2 = 1'b0;
    check("w_drain_id",    32'(id2),  32'd4);
    check("w_drain_ready", 32'(rdy2), 32'd0);
    check("w_drain_out",   out2,      32'hF0F0F0F0);
    tick();
    check("w_drain_done_id", 32'(id2), 32'd0);
    v2 = 1'b1; c2 = OP_RSVD; tick();
    v2 = 1'b0;
    check("w_fault_id",    32'(id2),  32'd5);
    check("w_fault_ready", 32'(rdy2), 32'd0);
    check("w_fault_cnt",   32'(cnt2), 32'd1);
    tick();
    check("w_lock_done_ready", 32'(rdy2), 32'd1);
    v2 = 1'b1; c2 = OP_CLEAR; tick();
    v2 = 1'b0;
    check("w_clear_id",  32'(id2),  32'd0);
    check("w_clear_out", out2,      32'h55555555);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
